// File: rtl/y86_pkg.sv
// Shared Y86 constants: register ids, default widths, instruction codes and
// helpers used by the forwarding register file.
package y86_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 4;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  function automatic int pend_w(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/forward_regfile_pend_counter.sv
// Per-register in-flight write counter: adds issues, subtracts retirements in
// one step, clamps at zero and at MAX_PEND, and is cleared by flush.
module pend_counter
  import y86_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int CW       = pend_w(MAX_PEND)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic [1:0]    inc_i,
  input  logic [1:0]    dec_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW+1:0] sum_s;
  logic [CW+1:0] dec_s;
  logic [CW+1:0] diff_s;

  // Net change for this cycle; retirements beyond the pending count bottom out at zero.
  always_comb begin
    sum_s  = {2'b00, cnt_q} + {{CW{1'b0}}, inc_i};
    dec_s  = {{CW{1'b0}}, dec_i};
    diff_s = sum_s - dec_s;
    if (flush_i) begin
      cnt_d = '0;
    end else if (sum_s <= dec_s) begin
      cnt_d = '0;
    end else if (diff_s > (CW+2)'(MAX_PEND)) begin
      cnt_d = CW'(MAX_PEND);
    end else begin
      cnt_d = diff_s[CW-1:0];
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/forward_regfile.sv
// Register file with two writeback ports, per-register pending-write tracking
// and issue throttling. Define REGFILE_BYPASS_EN to forward same-cycle writes.
module forward_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NREGS    = 15,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = 2,
  parameter int MAX_PEND = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic                  iss_valid_i,
  input  logic [ADDR_W-1:0]     iss_dstE_i,
  input  logic [ADDR_W-1:0]     iss_dstM_i,
  output logic                  iss_ready_o,
  input  logic [ADDR_W-1:0]     wbE_addr_i,
  input  logic [ADDR_W-1:0]     wbM_addr_i,
  input  logic [DATA_W-1:0]     wbE_data_i,
  input  logic [DATA_W-1:0]     wbM_data_i,
  input  logic                  flush_i
);

  localparam int CW = pend_w(MAX_PEND);

  function automatic logic is_reg(input logic [ADDR_W-1:0] a);
    return (a != {ADDR_W{1'b1}}) && (32'(a) < NREGS);
  endfunction

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CW-1:0]     cnt_s  [NREGS];
  logic [1:0]        need_s [NREGS];
  logic [1:0]        inc_s  [NREGS];
  logic [1:0]        dec_s  [NREGS];
  logic [ADDR_W-1:0] rd_a_s [NRD];
  logic              de_ok_s, dm_ok_s, we_e_s, we_m_s, iss_acc_s;

  // Decode which ports actually target an architectural register.
  always_comb begin
    de_ok_s   = is_reg(iss_dstE_i);
    dm_ok_s   = is_reg(iss_dstM_i);
    we_e_s    = is_reg(wbE_addr_i);
    we_m_s    = is_reg(wbM_addr_i);
    iss_acc_s = iss_valid_i && iss_ready_o;
  end

  // Per-register demand of the issuing instruction and this cycle's retirements.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      need_s[i] = {1'b0, de_ok_s && (iss_dstE_i == ADDR_W'(i))}
                + {1'b0, dm_ok_s && (iss_dstM_i == ADDR_W'(i))};
      dec_s[i]  = {1'b0, we_e_s && (wbE_addr_i == ADDR_W'(i))}
                + {1'b0, we_m_s && (wbM_addr_i == ADDR_W'(i))};
    end
  end

  // Issue is refused when any destination would overflow; retirements are not credited.
  always_comb begin
    iss_ready_o = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      if ((int'(cnt_s[i]) + int'(need_s[i])) > MAX_PEND) begin
        iss_ready_o = 1'b0;
      end else begin
        iss_ready_o = iss_ready_o;
      end
    end
  end

  // Only an accepted issue allocates.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (iss_acc_s) begin
        inc_s[i] = need_s[i];
      end else begin
        inc_s[i] = 2'b00;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cnt
    pend_counter #(
      .MAX_PEND (MAX_PEND),
      .CW       (CW)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (flush_i),
      .inc_i   (inc_s[g]),
      .dec_i   (dec_s[g]),
      .cnt_o   (cnt_s[g])
    );
  end

  // Register storage; M port wins when both writebacks hit the same register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_m_s && (wbM_addr_i == ADDR_W'(i))) begin
          regs_q[i] <= wbM_data_i;
        end else if (we_e_s && (wbE_addr_i == ADDR_W'(i))) begin
          regs_q[i] <= wbE_data_i;
        end else begin
          regs_q[i] <= regs_q[i];
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd_a
    assign rd_a_s[k] = rd_addr_i[k*ADDR_W +: ADDR_W];
  end

  // Combinational read ports; RNONE reads as zero and never busy.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int i = 0; i < NREGS; i++) begin
        if (is_reg(rd_a_s[k]) && (rd_a_s[k] == ADDR_W'(i))) begin
`ifdef REGFILE_BYPASS_EN
          if (we_m_s && (wbM_addr_i == rd_a_s[k])) begin
            rd_data_o[k*DATA_W +: DATA_W] = wbM_data_i;
          end else if (we_e_s && (wbE_addr_i == rd_a_s[k])) begin
            rd_data_o[k*DATA_W +: DATA_W] = wbE_data_i;
          end else begin
            rd_data_o[k*DATA_W +: DATA_W] = regs_q[i];
          end
          rd_busy_o[k] = int'(cnt_s[i]) > int'(dec_s[i]);
`else
          rd_data_o[k*DATA_W +: DATA_W] = regs_q[i];
          rd_busy_o[k] = (cnt_s[i] != '0);
`endif
        end else begin
          rd_busy_o[k] = rd_busy_o[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_forward_regfile.sv
// Self-checking bench for forward_regfile: directed scenarios then random
// traffic, compared against an array-based reference model.
module tb_forward_regfile;
  import y86_pkg::*;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int NR = 15;
  localparam int MP = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]    rd_busy;
  logic          iss_valid, iss_ready, flush;
  logic [AW-1:0] dstE, dstM, wbE_addr, wbM_addr;
  logic [DW-1:0] wbE_data, wbM_data;

  int n_pass = 0;
  int n_tot  = 0;

  logic [DW-1:0] m_mem [16];
  int            m_cnt [16];

  always #5 clk = ~clk;

  forward_regfile dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .iss_valid_i(iss_valid),
    .iss_dstE_i (dstE),
    .iss_dstM_i (dstM),
    .iss_ready_o(iss_ready),
    .wbE_addr_i (wbE_addr),
    .wbM_addr_i (wbM_addr),
    .wbE_data_i (wbE_data),
    .wbM_data_i (wbM_data),
    .flush_i    (flush)
  );

  function automatic bit vr(input logic [AW-1:0] a);
    return int'(a) < NR;
  endfunction

  function automatic int hits(input logic [AW-1:0] a);
    return ((vr(wbE_addr) && wbE_addr == a) ? 1 : 0) + ((vr(wbM_addr) && wbM_addr == a) ? 1 : 0);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (!vr(a)) return '0;
    if (BYP && vr(wbM_addr) && wbM_addr == a) return wbM_data;
    if (BYP && vr(wbE_addr) && wbE_addr == a) return wbE_data;
    return m_mem[a];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a);
    if (!vr(a)) return 1'b0;
    if (BYP) return (m_cnt[a] - hits(a)) > 0;
    return m_cnt[a] != 0;
  endfunction

  function automatic int need(input logic [AW-1:0] d);
    return ((vr(dstE) && dstE == d) ? 1 : 0) + ((vr(dstM) && dstM == d) ? 1 : 0);
  endfunction

  function automatic logic m_ready();
    if (vr(dstE) && m_cnt[dstE] + need(dstE) > MP) return 1'b0;
    if (vr(dstM) && m_cnt[dstM] + need(dstM) > MP) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; dstE = RNONE; dstM = RNONE; flush = 1'b0;
    wbE_addr = RNONE; wbM_addr = RNONE; wbE_data = '0; wbM_data = '0;
    rd_addr = {RNONE, RNONE};
  endtask

  task automatic m_reset();
    for (int r = 0; r < 16; r++) begin
      m_mem[r] = '0;
      m_cnt[r] = 0;
    end
  endtask

  // Called at a falling edge with inputs applied: check, clock, update model.
  task automatic step();
    bit acc;
    int v;
    #2;
    chk("rd_data0", rd_data[DW-1:0],  m_read(rd_addr[AW-1:0]));
    chk("rd_data1", rd_data[2*DW-1:DW], m_read(rd_addr[2*AW-1:AW]));
    chk("rd_busy0", 64'(rd_busy[0]), 64'(m_busy(rd_addr[AW-1:0])));
    chk("rd_busy1", 64'(rd_busy[1]), 64'(m_busy(rd_addr[2*AW-1:AW])));
    chk("iss_ready", 64'(iss_ready), 64'(m_ready()));
    acc = iss_valid && m_ready();
    @(posedge clk);
    if (rst_n) begin
      for (int r = 0; r < NR; r++) begin
        v = m_cnt[r] + (acc ? need(AW'(r)) : 0) - hits(AW'(r));
        m_cnt[r] = flush ? 0 : (v < 0 ? 0 : v);
      end
      if (vr(wbE_addr)) m_mem[wbE_addr] = wbE_data;
      if (vr(wbM_addr)) m_mem[wbM_addr] = wbM_data;
    end
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_ready", 64'(iss_ready), 64'd1);
    chk("reset_busy", 64'(rd_busy), 64'd0);
    step();
    rst_n = 1'b1;

    // Single write then read-back, plus RNONE read.
    wbE_addr = 4'd3; wbE_data = 64'h1234;
    step();
    idle(); rd_addr = {RNONE, 4'd3};
    #1;
    chk("r3_read", rd_data[DW-1:0], 64'h1234);
    chk("rnone_read", rd_data[2*DW-1:DW], 64'h0);
    step();

    // Both writeback ports hit r4: M data is kept.
    idle(); wbE_addr = 4'd4; wbE_data = 64'hAA; wbM_addr = 4'd4; wbM_data = 64'hBB; rd_addr = {RNONE, 4'd4};
`ifdef REGFILE_BYPASS_EN
    #1;
    chk("r4_bypass", rd_data[DW-1:0], 64'hBB);
`endif
    step();
    idle(); rd_addr = {RNONE, 4'd4};
    #1;
    chk("r4_stored", rd_data[DW-1:0], 64'hBB);
    step();

    // Fill r2 to MAX_PEND, see issue throttled, retire one.
    for (int n = 0; n < 3; n++) begin
      idle(); iss_valid = 1'b1; dstE = 4'd2; rd_addr = {RNONE, 4'd2};
      step();
    end
    idle(); iss_valid = 1'b1; dstE = 4'd2; rd_addr = {RNONE, 4'd2};
    #1;
    chk("r2_full_ready", 64'(iss_ready), 64'd0);
    chk("r2_busy", 64'(rd_busy[0]), 64'd1);
    step();
    idle(); wbE_addr = 4'd2; wbE_data = 64'h22; rd_addr = {RNONE, 4'd2};
    step();
    idle(); dstE = 4'd2;
    #1;
    chk("r2_ready_after_wb", 64'(iss_ready), 64'd1);
    step();

    // Issue and retire r5 together with counter at 1.
    idle(); iss_valid = 1'b1; dstE = 4'd5;
    step();
    idle(); iss_valid = 1'b1; dstE = 4'd5; wbE_addr = 4'd5; wbE_data = 64'h55; rd_addr = {RNONE, 4'd5};
    step();
    idle(); rd_addr = {RNONE, 4'd5};
    #1;
    chk("r5_busy_net", 64'(rd_busy[0]), 64'd1);
    step();

    // Flush clears every counter, overriding a same-cycle issue.
    idle(); iss_valid = 1'b1; dstE = 4'd1; dstM = 4'd1;
    step();
    idle(); iss_valid = 1'b1; dstE = 4'd6; rd_addr = {4'd6, 4'd1};
    step();
    idle(); flush = 1'b1; iss_valid = 1'b1; dstE = 4'd1; rd_addr = {4'd6, 4'd1};
    #1;
    chk("pre_flush_busy", 64'(rd_busy), 64'd3);
    step();
    idle(); rd_addr = {4'd6, 4'd1};
    #1;
    chk("post_flush_busy", 64'(rd_busy), 64'd0);
    step();
    idle(); wbE_addr = 4'd1; wbE_data = 64'h11;
    step();
    idle(); rd_addr = {4'd2, 4'd1};
    #1;
    chk("post_flush_wb_busy", 64'(rd_busy), 64'd0);
    step();

    // Asynchronous reset in the middle of a high phase.
    idle(); iss_valid = 1'b1; dstE = 4'd7;
    step();
    step();
    idle(); dstE = 4'd7; dstM = 4'd7; rd_addr = {4'd4, 4'd7};
    #1;
    chk("r7_ready_pre", 64'(iss_ready), 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(rd_busy), 64'd0);
    chk("rst_r4_data", rd_data[2*DW-1:DW], 64'h0);
    chk("rst_ready", 64'(iss_ready), 64'd1);
    m_reset();
    @(negedge clk);
    idle(); wbE_addr = 4'd3; wbE_data = 64'hDEAD; rd_addr = {4'd4, 4'd3};
    step();
    idle(); rst_n = 1'b1; rd_addr = {4'd4, 4'd3};
    #1;
    chk("no_write_in_reset", rd_data[DW-1:0], 64'h0);
    step();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      idle();
      iss_valid = $urandom_range(0, 1) == 1;
      dstE      = AW'($urandom_range(0, 15));
      dstM      = ($urandom_range(0, 3) == 0) ? dstE : AW'($urandom_range(0, 15));
      wbE_addr  = AW'($urandom_range(0, 15));
      wbM_addr  = ($urandom_range(0, 5) == 0) ? wbE_addr : AW'($urandom_range(0, 15));
      wbE_data  = {$urandom, $urandom};
      wbM_data  = {$urandom, $urandom};
      flush     = $urandom_range(0, 31) == 0;
      rd_addr   = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wbE_addr;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
